seq_subtractor: RTL

- Parametrised multi-cycle subtractor and successor to the single-bit full subtractor.
- Computes a - b - bin, or b - a - bin when reversed, over WIDTH bits.
- Processes DIGIT bits per clock, LSB digit first, through a rippled full-subtractor borrow chain.
- Uses a start/done handshake and reports borrow-out, signed overflow and zero flags. It is the shared arithmetic unit for wider datapaths built from the 1-bit cells.

---
 rtl/seq_subtractor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: a-b-bin (or b-a-bin when rev) over WIDTH bits,
// processed DIGIT bits per clock through a rippled full-subtractor borrow chain.
module seq_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             rev,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  // DIGIT must divide WIDTH; N digits per operation.
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_work;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_shamt;
  logic [DIGIT-1:0] w_x;
  logic [DIGIT-1:0] w_y;
  logic [DIGIT-1:0] w_d;
  logic             w_br_out;
  logic [WIDTH-1:0] w_work_next;
  logic             w_ovf_next;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_cnt == LAST);
  assign w_shamt  = 32'(r_cnt) * DIGIT;
  assign w_x      = DIGIT'(r_opa >> w_shamt);
  assign w_y      = DIGIT'(r_opb >> w_shamt);

  always_comb begin
    logic v_br;
    v_br = r_borrow;
    w_d  = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      w_d[i] = w_x[i] ^ w_y[i] ^ v_br;
      v_br   = (~w_x[i] & w_y[i]) | (~w_x[i] & v_br) | (w_y[i] & v_br);
    end
    w_br_out = v_br;
  end

  // Work register is cleared on acceptance, so OR-ing in each digit suffices.
  assign w_work_next = r_work | (WIDTH'(w_d) << w_shamt);
  assign w_ovf_next  = (r_opa[WIDTH-1] ^ r_opb[WIDTH-1]) &
                       (w_work_next[WIDTH-1] ^ r_opa[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_work   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_opa    <= rev ? b : a;
      r_opb    <= rev ? a : b;
      r_work   <= '0;
      r_borrow <= bin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_work   <= w_work_next;
      r_borrow <= w_br_out;
      r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_work_next;
        r_bout <= w_br_out;
        r_ovf  <= w_ovf_next;
        r_zero <= (w_work_next == '0);
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule
